// File: rtl/delay_calibrator.sv
// Delay-line auto-calibration controller: sweeps every non-reference channel through all taps and
// programs the tap with the most coincidences against channel 0. Define DLYCAL_HIST_EN to add BestCnt.
module delay_calibrator #(
  parameter int unsigned NCHAN  = 4,
  parameter int unsigned NREGS  = 10,
  parameter int unsigned WINDOW = 1000
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  input  logic                              Start,
  input  logic                              Abort,
  input  logic                              WrEn,
  input  logic [$clog2(NCHAN)-1:0]          WrChan,
  input  logic [$clog2(NREGS)-1:0]          WrData,
  input  logic [NCHAN-1:0]                  DlayChann,
  output logic [NCHAN*$clog2(NREGS)-1:0]    Delays,
  output logic                              Busy,
  output logic                              Done,
  output logic [NCHAN-1:0]                  NoCoinc
`ifdef DLYCAL_HIST_EN
  ,
  output logic [NCHAN*$clog2(WINDOW+1)-1:0] BestCnt
`endif
);

  localparam int unsigned DW  = $clog2(NREGS);
  localparam int unsigned CW  = $clog2(WINDOW + 1);
  localparam int unsigned CHW = $clog2(NCHAN);
  localparam int unsigned SW  = $clog2(NREGS + 3);
  localparam int unsigned TW  = (CW > SW) ? CW : SW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_SETTLE,
    S_COUNT,
    S_EVAL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state;
  logic [DW-1:0]   dly [NCHAN];
  logic [DW-1:0]   restore;
  logic [CHW-1:0]  chan;
  logic [DW-1:0]   tap;
  logic [DW-1:0]   best_tap;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   best;
  logic [TW-1:0]   timer;
  logic            coinc;
  logic            wr_hit;
  logic [DW-1:0]   wr_val;
`ifdef DLYCAL_HIST_EN
  logic [CW-1:0]   best_cnt [NCHAN];
`endif

  // Host write decode: drop out-of-range channels, clamp out-of-range taps.
  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (WrChan == CHW'(i)) wr_hit = 1'b1;
    end
    wr_val = (WrData >= DW'(NREGS)) ? DW'(NREGS - 1) : WrData;
  end

  assign coinc = DlayChann[0] & DlayChann[chan];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      NoCoinc  <= '0;
      restore  <= '0;
      chan     <= '0;
      tap      <= '0;
      best_tap <= '0;
      cnt      <= '0;
      best     <= '0;
      timer    <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        dly[i] <= '0;
`ifdef DLYCAL_HIST_EN
        best_cnt[i] <= '0;
`endif
      end
    end else if ((state != S_IDLE) && Abort) begin
      // The channel under sweep gets its pre-sweep value back; finished channels keep theirs.
      if (state != S_DONE) dly[chan] <= restore;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            chan     <= CHW'(1);
            tap      <= '0;
            best     <= '0;
            best_tap <= '0;
            restore  <= dly[1];
            NoCoinc  <= '0;
            Busy     <= 1'b1;
            state    <= S_SET;
          end else if (WrEn && wr_hit) begin
            dly[WrChan] <= wr_val;
          end
        end
        S_SET: begin
          dly[chan] <= tap;
          timer     <= '0;
          cnt       <= '0;
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          // NREGS+2 cycles lets the old tap drain out of the delay pipeline.
          if (timer == TW'(NREGS + 1)) begin
            timer <= '0;
            state <= S_COUNT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_COUNT: begin
          if (coinc && (cnt != '1)) cnt <= cnt + CW'(1);
          if (timer == TW'(WINDOW - 1)) begin
            state <= S_EVAL;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_EVAL: begin
          if (cnt > best) begin
            best     <= cnt;
            best_tap <= tap;
          end
          if (tap == DW'(NREGS - 1)) begin
            state <= S_NEXT;
          end else begin
            tap   <= tap + DW'(1);
            state <= S_SET;
          end
        end
        S_NEXT: begin
          dly[chan]     <= best_tap;
          NoCoinc[chan] <= (best == '0);
`ifdef DLYCAL_HIST_EN
          best_cnt[chan] <= best;
`endif
          if (chan == CHW'(NCHAN - 1)) begin
            state <= S_DONE;
          end else begin
            chan     <= chan + CHW'(1);
            restore  <= dly[chan + CHW'(1)];
            tap      <= '0;
            best     <= '0;
            best_tap <= '0;
            state    <= S_SET;
          end
        end
        S_DONE: begin
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_out
    assign Delays[g*DW +: DW] = dly[g];
`ifdef DLYCAL_HIST_EN
    assign BestCnt[g*CW +: CW] = best_cnt[g];
`endif
  end

endmodule
